imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a byte stream (16-bit word count, then little-endian words),
// writes each word to instruction memory and holds the core in reset until the image is complete.
module imem_loader #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_x,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StHdr0,
    StHdr1,
    StData,
    StDone,
    StErr
  } state_e;

  // Largest legal word count is the full memory depth.
  localparam logic [32:0] MaxWords = 33'd1 << ADDR_W;

  state_e          state_q;
  logic [15:0]     n_words_q;
  logic [1:0]      byte_cnt_q;
  logic [ADDR_W:0] word_idx_q;
  logic [23:0]     word_buf_q;

  logic        accept;
  logic [15:0] hdr_n;
  logic        n_zero;
  logic        n_too_big;
  logic        last_word;

  always_comb begin
    accept    = in_valid & in_ready;
    hdr_n     = {in_data, n_words_q[7:0]};
    n_zero    = (hdr_n == 16'd0);
    n_too_big = (33'(hdr_n) > MaxWords);
    last_word = ((33'(word_idx_q) + 33'd1) == 33'(n_words_q));
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q    <= StHdr0;
      n_words_q  <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      word_buf_q <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst_x <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state_q)
        StHdr0: begin
          in_ready <= 1'b1;
          if (accept) begin
            n_words_q[7:0] <= in_data;
            state_q        <= StHdr1;
          end
        end
        StHdr1: begin
          in_ready <= 1'b1;
          if (accept) begin
            n_words_q[15:8] <= in_data;
            if (n_zero) begin
              state_q  <= StDone;
              in_ready <= 1'b0;
            end else if (n_too_big) begin
              state_q  <= StErr;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          in_ready <= 1'b1;
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              mem_we     <= 1'b1;
              mem_addr   <= word_idx_q[ADDR_W-1:0];
              mem_wdata  <= {in_data, word_buf_q};
              word_idx_q <= word_idx_q + 1'b1;
              // Enter DONE while the final write strobe is on the bus.
              if (last_word) begin
                state_q  <= StDone;
                in_ready <= 1'b0;
              end
            end else begin
              // Bytes arrive low first, so shift in from the top.
              word_buf_q <= {in_data, word_buf_q[23:8]};
            end
          end
        end
        StDone: begin
          in_ready   <= 1'b0;
          done       <= 1'b1;
          core_rst_x <= 1'b1;
        end
        StErr: begin
          in_ready <= 1'b0;
        end
        default: begin
          state_q  <= StHdr0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
